// File: rtl/td4_pkg.sv
// rtl/td4_pkg.sv - shared TD4 control definitions
//
// Purpose: opcode encodings, register-load bit positions, ALU source
// encodings and the sequencer state type used by the TD4 control unit.
// Ports: none (package).

package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_e;

endpackage

// File: rtl/td4_sequencer_if.sv
// rtl/td4_sequencer_if.sv - ROM / register-file bus of the TD4 sequencer
//
// Purpose: groups the instruction fetch input and register-file control
// signals between the sequencer and the ROM/REGISTERS blocks.
// Signals:
//   rom_data [7:0] instruction at the current PC
//   carry_n        registered carry flag (0 = carry set)
//   load_n   [3:0] active-low loads: A, B, OUT, PC
//   select   [1:0] ALU source select
//   immed    [3:0] ALU immediate
//   regs_en        register-file update enable
// Modports: master = sequencer side, slave = ROM/register-file side.

interface td4_sequencer_if;
  logic [7:0] rom_data;
  logic       carry_n;
  logic [3:0] load_n;
  logic [1:0] select;
  logic [3:0] immed;
  logic       regs_en;

  modport master (
    input  rom_data,
    input  carry_n,
    output load_n,
    output select,
    output immed,
    output regs_en
  );

  modport slave (
    output rom_data,
    output carry_n,
    input  load_n,
    input  select,
    input  immed,
    input  regs_en
  );
endinterface

// File: rtl/td4_decode.sv
// rtl/td4_decode.sv - TD4 instruction decoder
//
// Purpose: combinational decode of an instruction byte into register-file
// controls.
// Ports:
//   ir      [7:0] in   instruction ([7:4] opcode, [3:0] immediate)
//   carry_n       in   carry flag, 0 = carry set (used by JNC)
//   load_n  [3:0] out  active-low loads: A, B, OUT, PC
//   select  [1:0] out  ALU source select
//   immed   [3:0] out  immediate, forced to 0 for register moves and IN
//   illegal       out  opcode is not part of the instruction set

module td4_decode
  import td4_pkg::*;
(
  input  logic [7:0] ir,
  input  logic       carry_n,
  output logic [3:0] load_n,
  output logic [1:0] select,
  output logic [3:0] immed,
  output logic       illegal
);

  always_comb begin
    load_n  = 4'b1111;
    select  = SEL_A;
    immed   = ir[3:0];
    illegal = 1'b0;
    case (ir[7:4])
      OP_ADD_A:  begin select = SEL_A;    load_n[LD_A]   = 1'b0; end
      OP_ADD_B:  begin select = SEL_B;    load_n[LD_B]   = 1'b0; end
      OP_MOV_A:  begin select = SEL_ZERO; load_n[LD_A]   = 1'b0; end
      OP_MOV_B:  begin select = SEL_ZERO; load_n[LD_B]   = 1'b0; end
      OP_MOV_AB: begin select = SEL_B;    load_n[LD_A]   = 1'b0; immed = 4'd0; end
      OP_MOV_BA: begin select = SEL_A;    load_n[LD_B]   = 1'b0; immed = 4'd0; end
      OP_IN_A:   begin select = SEL_IN;   load_n[LD_A]   = 1'b0; immed = 4'd0; end
      OP_IN_B:   begin select = SEL_IN;   load_n[LD_B]   = 1'b0; immed = 4'd0; end
      OP_OUT_B:  begin select = SEL_B;    load_n[LD_OUT] = 1'b0; immed = 4'd0; end
      OP_OUT_IM: begin select = SEL_ZERO; load_n[LD_OUT] = 1'b0; end
      OP_JMP:    begin select = SEL_ZERO; load_n[LD_PC]  = 1'b0; end
      // Jump only when carry is clear; otherwise no load, so PC auto-increments.
      OP_JNC:    begin select = SEL_ZERO; load_n[LD_PC]  = ~carry_n; end
      default: begin
        illegal = 1'b1;
        immed   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// rtl/td4_sequencer.sv - TD4 CPU control unit
//
// Purpose: fetches the instruction at the register file's PC, decodes it and
// issues one register-file update cycle per instruction. Free-run and
// single-step modes, halt on illegal opcodes, retired-instruction counter.
// Ports:
//   clk             in   clock, rising edge
//   clr             in   synchronous active-high reset
//   run             in   level, execute continuously
//   step_req        in   level, request one instruction while run=0
//   step_ack        out  one-cycle pulse in EXEC of a stepped instruction
//   halted          out  1 while in HALT
//   instr_cnt [CNT_W-1:0] out  retired instructions, wraps
//   bus             master side of td4_sequencer_if (ROM + register file)

module td4_sequencer
  import td4_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter int HALT_ON_ILLEGAL = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  td4_sequencer_if.master  bus
);

  state_e           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] dec_load_n;
  logic [1:0] dec_select;
  logic [3:0] dec_immed;
  logic       dec_illegal;
  logic       halt_now;
  logic       in_exec;

  // Decode works from the latched IR only, so rom_data never reaches load_n
  // combinationally.
  td4_decode u_decode (
    .ir      (ir_q),
    .carry_n (bus.carry_n),
    .load_n  (dec_load_n),
    .select  (dec_select),
    .immed   (dec_immed),
    .illegal (dec_illegal)
  );

  assign halt_now = dec_illegal && (HALT_ON_ILLEGAL != 0);

  // clr suppresses the EXEC outputs so a reset mid-instruction never
  // produces a register-file update.
  assign in_exec = (state_q == EXEC) && !clr;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          step_d  = 1'b0;
        end else if (step_req) begin
          state_d = FETCH;
          step_d  = 1'b1;
        end
      end
      FETCH: begin
        ir_d    = bus.rom_data;
        state_d = EXEC;
      end
      EXEC: begin
        step_d = 1'b0;
        if (halt_now) begin
          state_d = HALT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = run ? FETCH : IDLE;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      ir_q    <= 8'd0;
      step_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_n  = in_exec ? dec_load_n : 4'b1111;
  assign bus.select  = in_exec ? dec_select : SEL_A;
  assign bus.immed   = in_exec ? dec_immed  : 4'd0;
  assign bus.regs_en = in_exec && !halt_now;
  assign step_ack    = in_exec && step_q;
  assign halted      = (state_q == HALT);
  assign instr_cnt   = cnt_q;

endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
- Control unit for the TD4 CPU.
- Fetches the 8-bit instruction addressed by the register file's PC, decodes it and drives the register file's load_n, select and immed controls for exactly one update cycle per instruction.
- Supports free-run and single-step (req/ack) modes, halts on illegal opcodes and counts retired instructions.
- Sits between the program ROM and the REGISTERS block in the CPU top level.

Parameters:
- CNT_W, 8: width of retired-instruction counter; wraps modulo 2^CNT_W.
- HALT_ON_ILLEGAL, 1: 1 = illegal opcode enters HALT; 0 = illegal opcode retires as NOP (PC increments, no register load).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- clr  input  1  synchronous active-high reset.
- run  input  1  level; 1 = execute continuously.
- step_req  input  1  level; request one instruction while run=0; held until step_ack.
- step_ack  output  1  one-cycle pulse in the EXEC cycle of a stepped instruction.
- rom_data  input  8  instruction at addr_rom; [7:4] opcode, [3:0] immediate.
- carry_n  input  1  registered carry flag from REGISTERS (0 = carry set).
- load_n  output  4  active-low loads: bit0 A, bit1 B, bit2 OUT, bit3 PC.
- select  output  2  ALU source: 00 A, 01 B, 10 in port, 11 zero.
- immed  output  4  immediate added by the ALU.
- regs_en  output  1  register-file update enable; PC auto-increment happens only when regs_en=1 and load_n[3]=1.
- halted  output  1  1 while in HALT.
- instr_cnt  output  CNT_W  retired instructions.

Behaviour:
- Reset (clr=1 at edge): state IDLE, IR=0, load_n=4'b1111, select=00, immed=0, regs_en=0, step_ack=0, halted=0, instr_cnt=0. Reset mid-instruction aborts it; no regs_en pulse is issued in the reset cycle.
- IDLE:
  - run=1 -> FETCH.
  - Else step_req=1 -> FETCH with step flag set.
  - Else stay.
- FETCH (1 cycle):
  - IR <= rom_data.
  - Outputs idle: load_n=1111, regs_en=0.
  - Next state is EXEC.
- EXEC (1 cycle):
  - Decode from IR.
  - Drive load_n, select and immed=IR[3:0].
  - regs_en=1; instr_cnt += 1.
  - step_ack=1 if step flag set; step flag clears.
- Next state from EXEC:
  - run=1 -> FETCH.
  - Else IDLE.
  - The IDLE round-trip guarantees step_req is sampled only after the ack.
- Instruction latency: 2 cycles (FETCH+EXEC) in run mode.
- Decode (opcode: select, load):
  - 0000 ADD A,Im: 00, A.
  - 0101 ADD B,Im: 01, B.
  - 0011 MOV A,Im: 11, A.
  - 0111 MOV B,Im: 11, B.
  - 0001 MOV A,B: 01, A, immed forced 0.
  - 0100 MOV B,A: 00, B, immed forced 0.
  - 0010 IN A: 10, A, immed forced 0.
  - 0110 IN B: 10, B, immed forced 0.
  - 1001 OUT B: 01, OUT, immed forced 0.
  - 1011 OUT Im: 11, OUT.
  - 1111 JMP Im: 11, PC.
  - 1110 JNC Im: 11, PC only if carry_n=1; else no load (PC increments).
- Illegal opcodes (any other) with HALT_ON_ILLEGAL=1:
  - No regs_en pulse and no count.
  - step_ack still pulses if stepping.
  - Next state HALT.
- HALT:
  - halted=1, outputs idle.
  - Exits only via clr; run and step_req are ignored.
- run falling during EXEC: that instruction completes, then IDLE.
- step_req while run=1: ignored, step_ack never pulses.
- instr_cnt at 2^CNT_W-1 wraps to 0.
- All outputs registered or decoded from state/IR only. No combinational path from rom_data to load_n.

Decomposition:
- Shared package td4_pkg holds:
  - opcode localparams.
  - Load bit positions (LD_A=0, LD_B=1, LD_OUT=2, LD_PC=3).
  - Select encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO).
  - State enum (IDLE, FETCH, EXEC, HALT).
- One natural sub-module, td4_decode: combinational IR/carry_n -> load_n, select, immed, illegal. Reused by the verification reference model.

Test Plan:
- Reset then run=1, ROM[0]=0011_0101 (MOV A,5): FETCH at cycle 1, EXEC at cycle 2 with load_n=1110, select=11, immed=0101, regs_en=1; instr_cnt=1.
- Stepping, run=0, ROM[0]=0101_0110 (ADD B,6): hold step_req -> exactly one step_ack pulse in EXEC with load_n=1101, select=01; afterwards IDLE with no further regs_en until step_req re-asserted.
- JNC Im=1001:
  - carry_n=1 -> load_n=0111, immed=1001.
  - carry_n=0 -> load_n=1111, regs_en=1 (PC increments).
- Illegal opcode 1000_0000 in run mode: no regs_en; halted=1 from the next cycle; instr_cnt unchanged; remains halted with run=1 for 10 cycles; clr returns to IDLE with all reset values.
- Counter wrap with CNT_W=2: 5 consecutive MOV A,Im -> instr_cnt sequence 1,2,3,0,1.
- clr asserted during EXEC: regs_en=0 that cycle, state IDLE, instr_cnt=0; run=1 restarts from FETCH.
